mux2_rr_arb: RTL and testbench
==============================

# mux2_rr_arb

Two-channel round-robin arbiter and registered output stage that sits directly upstream of the 2:1 multiplexer. It accepts words from two valid/ready sources A and B, decides which source is served each cycle, drives the select S for the mux stage, and presents the chosen word on a one-entry registered output with its own valid/ready handshake. Fairness is guaranteed: under continuous contention the two sources alternate.

## Interface
- W, default 8: data width of A, B and Y.

- CLK  input  1  single clock; all state updates on rising edge.
- RSTn  input  1  reset, asynchronous, active-low.
- A_VALID  input  1  source A has a word on A.
- A  input  W  source A data.
- A_READY  output  1  A word is accepted this cycle when A_VALID & A_READY.
- B_VALID  input  1  source B has a word on B.
- B  input  W  source B data.
- B_READY  output  1  B word is accepted this cycle when B_VALID & B_READY.
- S  output  1  registered select: 0 = word in Y came from A, 1 = from B.
- Y_VALID  output  1  Y holds a valid word.
- Y  output  W  registered output word.
- Y_READY  input  1  downstream accepts Y this cycle when Y_VALID & Y_READY.

## Operation
- State: output register (Y, S), Y_VALID flag, priority pointer LAST (1 bit: source granted most recently).
- Two FSM states encoded by Y_VALID: EMPTY (0), FULL (1).
- Reset (RSTn = 0, immediate, no clock needed): Y_VALID = 0, Y = 0, S = 0, LAST = 1 (A has priority on first contention); A_READY = B_READY = 0 while RSTn = 0.
- OPEN = !Y_VALID | Y_READY (register empty or draining this cycle).
- Grant (combinational, only when OPEN):
  - only A_VALID: grant A; only B_VALID: grant B;
  - both: grant the source != LAST;
  - neither: no grant.
- A_READY = OPEN & grant A; B_READY = OPEN & grant B. At most one READY high per cycle; READY never high for a source whose VALID is low.
- On accept: Y <= granted data, S <= granted source, Y_VALID <= 1, LAST <= granted source.
- FULL & Y_READY & no accept: Y_VALID <= 0; Y and S keep last values.
- FULL & !Y_READY: Y, S, Y_VALID, LAST held; both READYs 0.
- EMPTY & no valid source: everything held.
- LAST changes only on an accept.

## Timing
- Latency: word accepted in cycle n appears on Y with Y_VALID = 1 from cycle n+1.
- Throughput: one word per cycle when Y_READY held 1 (drain and accept in same cycle replaces the word, no bubble).
- A_READY/B_READY are combinational from A_VALID, B_VALID, Y_VALID, Y_READY, LAST; sources must not make VALID depend on READY.
- Y, S, Y_VALID are pure register outputs (no combinational path from inputs).
- While Y_VALID & !Y_READY, Y and S stable cycle to cycle.
- Sources hold VALID and data until accepted; a withdrawn request is simply not granted.
- Reset asserted mid-transfer: word in Y discarded, Y_VALID = 0 immediately; first cycle after RSTn rises behaves as EMPTY with LAST = 1.

## Test plan
- Reset: drive RSTn = 0 mid-simulation with Y_VALID = 1 -> Y_VALID, Y, S go to 0 without a clock edge; A_READY = B_READY = 0.
- Single source: A_VALID = 1, A = 8'h3C, B_VALID = 0, Y_READY = 1 -> A_READY = 1; next cycle Y = 8'h3C, S = 0, Y_VALID = 1.
- Contention after reset: A = 8'h11, B = 8'h22 both valid, Y_READY = 1 for 4 cycles -> Y sequence 11, 22, 11, 22; S sequence 0, 1, 0, 1; one READY per cycle.
- Backpressure: Y holds 8'hA5 (S = 1), Y_READY = 0 for 3 cycles with both sources valid -> Y = 8'hA5, S = 1 stable, A_READY = B_READY = 0; on Y_READY = 1 A is granted (LAST = B).
- Fairness after idle B: A alone accepted for 3 cycles, then B_VALID rises with A_VALID still 1 -> B granted in that cycle (LAST = A).
- Drain without refill: FULL, Y_READY = 1, no source valid -> next cycle Y_VALID = 0, Y and S unchanged.

Source files
------------

// File: rtl/mux2_rr_arb.sv
// Two-source round-robin arbiter feeding a one-entry registered output stage.
// It drives the select S for the downstream 2:1 mux and alternates sources under contention.
module mux2_rr_arb #(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         RSTn,
  input  logic         A_VALID,
  input  logic [W-1:0] A,
  output logic         A_READY,
  input  logic         B_VALID,
  input  logic [W-1:0] B,
  output logic         B_READY,
  output logic         S,
  output logic         Y_VALID,
  output logic [W-1:0] Y,
  input  logic         Y_READY
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t state;
  logic   last;
  logic   open;
  logic   gnt_a;
  logic   gnt_b;

  assign Y_VALID = (state == FULL);

  // The register can take a new word when empty or when its current word leaves this cycle.
  always_comb begin
    open  = (state == EMPTY) || Y_READY;
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (RSTn && open) begin
      if (A_VALID && B_VALID) begin
        gnt_a = last;
        gnt_b = !last;
      end else begin
        gnt_a = A_VALID;
        gnt_b = B_VALID;
      end
    end
  end

  assign A_READY = gnt_a;
  assign B_READY = gnt_b;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state <= EMPTY;
      Y     <= '0;
      S     <= 1'b0;
      last  <= 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (gnt_a || gnt_b) begin
            Y     <= gnt_b ? B : A;
            S     <= gnt_b;
            last  <= gnt_b;
            state <= FULL;
          end
        end
        FULL: begin
          if (gnt_a || gnt_b) begin
            Y     <= gnt_b ? B : A;
            S     <= gnt_b;
            last  <= gnt_b;
          end else if (Y_READY) begin
            state <= EMPTY;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_mux2_rr_arb.sv
// Bench for mux2_rr_arb: directed scenarios with literal expectations, then
// protocol-respecting random traffic compared each cycle against a behavioural model.
module tb_mux2_rr_arb;
  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         RSTn = 1'b0;
  logic         A_VALID = 1'b0;
  logic [W-1:0] A = '0;
  logic         A_READY;
  logic         B_VALID = 1'b0;
  logic [W-1:0] B = '0;
  logic         B_READY;
  logic         S;
  logic         Y_VALID;
  logic [W-1:0] Y;
  logic         Y_READY = 1'b0;

  mux2_rr_arb #(.W(W)) dut (
    .CLK(CLK), .RSTn(RSTn),
    .A_VALID(A_VALID), .A(A), .A_READY(A_READY),
    .B_VALID(B_VALID), .B(B), .B_READY(B_READY),
    .S(S), .Y_VALID(Y_VALID), .Y(Y), .Y_READY(Y_READY)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Model: output slot contents plus which source was served most recently.
  bit           m_vld;
  bit           m_s;
  bit           m_served_b;
  logic [W-1:0] m_y;
  bit           e_ra, e_rb;
  bit           d_ra, d_rb;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_vld = 0; m_s = 0; m_y = '0; m_served_b = 1;
  endtask

  // A requester alone always wins; two requesters -> whoever was not served last.
  task automatic model_ready();
    bit room;
    room = !m_vld || Y_READY;
    e_ra = 0; e_rb = 0;
    if (room) begin
      if (A_VALID && B_VALID) begin
        if (m_served_b) e_ra = 1; else e_rb = 1;
      end else begin
        e_ra = A_VALID;
        e_rb = B_VALID;
      end
    end
  endtask

  task automatic compare();
    chk("a_ready", A_READY, e_ra);
    chk("b_ready", B_READY, e_rb);
    chk("y_valid", Y_VALID, m_vld);
    chk("y", Y, m_y);
    chk("s", S, m_s);
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic step(input bit av, input logic [W-1:0] a, input bit bv,
                      input logic [W-1:0] b, input bit yr);
    A_VALID = av; A = a; B_VALID = bv; B = b; Y_READY = yr;
    #2;
    model_ready();
    d_ra = A_READY;
    d_rb = B_READY;
    compare();
    @(posedge CLK);
    if (e_ra) begin
      m_y = a; m_s = 0; m_vld = 1; m_served_b = 0;
    end else if (e_rb) begin
      m_y = b; m_s = 1; m_vld = 1; m_served_b = 1;
    end else if (m_vld && yr) begin
      m_vld = 0;
    end
    @(negedge CLK);
  endtask

  // Asynchronous reset pulse between clock edges, with both sources requesting.
  task automatic mid_reset();
    A_VALID = 1; B_VALID = 1; Y_READY = 1;
    #3;
    RSTn = 0;
    #1;
    chk("rst_y_valid", Y_VALID, 1'b0);
    chk("rst_y", Y, 8'h00);
    chk("rst_s", S, 1'b0);
    chk("rst_a_ready", A_READY, 1'b0);
    chk("rst_b_ready", B_READY, 1'b0);
    model_reset();
    @(negedge CLK);
    RSTn = 1;
  endtask

  bit           rav, rbv, ryr;
  logic [W-1:0] ra, rb;

  initial begin
    model_reset();
    A_VALID = 1; B_VALID = 1;
    #1;
    chk("init_y_valid", Y_VALID, 1'b0);
    chk("init_a_ready", A_READY, 1'b0);
    chk("init_b_ready", B_READY, 1'b0);
    @(negedge CLK);
    RSTn = 1;

    // Single source A
    step(1, 8'h3C, 0, 8'h00, 1);
    chk("single_a_ready", d_ra, 1'b1);
    chk("single_y", Y, 8'h3C);
    chk("single_s", S, 1'b0);
    chk("single_vld", Y_VALID, 1'b1);

    // Reset while holding a word
    mid_reset();

    // Contention right after reset: A first, then alternate
    for (int i = 0; i < 4; i++) begin
      step(1, 8'h11, 1, 8'h22, 1);
      chk("cont_y", Y, (i % 2) ? 8'h22 : 8'h11);
      chk("cont_s", S, i % 2);
      chk("cont_one_ready", d_ra ^ d_rb, 1'b1);
    end

    // Backpressure with A5 from B in the register
    step(0, 8'h00, 1, 8'hA5, 1);
    for (int i = 0; i < 3; i++) begin
      step(1, 8'h11, 1, 8'h22, 0);
      chk("bp_y", Y, 8'hA5);
      chk("bp_s", S, 1'b1);
      chk("bp_ready", {d_ra, d_rb}, 2'b00);
    end
    step(1, 8'h11, 1, 8'h22, 1);
    chk("bp_release_a", d_ra, 1'b1);
    chk("bp_release_y", Y, 8'h11);

    // A alone for three words, then B joins and must win
    for (int i = 0; i < 3; i++) begin
      step(1, 8'h30 + 8'(i), 0, 8'h00, 1);
      chk("fair_a_ready", d_ra, 1'b1);
    end
    step(1, 8'h40, 1, 8'h50, 1);
    chk("fair_b_ready", d_rb, 1'b1);
    chk("fair_y", Y, 8'h50);

    // Drain with nothing to refill
    step(0, 8'h00, 0, 8'h00, 1);
    chk("drain_vld", Y_VALID, 1'b0);
    chk("drain_y", Y, 8'h50);
    chk("drain_s", S, 1'b1);

    // Random traffic; sources hold their word until it is taken
    rav = 0; rbv = 0; ra = '0; rb = '0;
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) mid_reset();
      if (!rav) begin rav = 1'($urandom % 2); ra = W'($urandom); end
      if (!rbv) begin rbv = 1'($urandom % 2); rb = W'($urandom); end
      ryr = ($urandom % 4) != 0;
      step(rav, ra, rbv, rb, ryr);
      if (e_ra) rav = 0;
      if (e_rb) rbv = 0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
